// File: rtl/ccd_pkg.sv
// Shared constants and types for the CCD acquisition scheduler:
// host opcodes, sync bytes, parser/TX state encodings, clamp helper.
package ccd_pkg;

  localparam int INT_W = 24;

  localparam logic [7:0] OP_SET_INT = 8'h01;
  localparam logic [7:0] OP_SINGLE  = 8'h02;
  localparam logic [7:0] OP_CONT    = 8'h03;
  localparam logic [7:0] OP_STOP    = 8'h04;
  localparam logic [7:0] OP_STATUS  = 8'h05;

  localparam logic [7:0] SYNC_H0 = 8'hA5;
  localparam logic [7:0] SYNC_H1 = 8'h5A;
  localparam logic [7:0] SYNC_ST = 8'h55;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_HDR0,
    TX_HDR1,
    TX_HDR2,
    TX_PIXELS,
    TX_STAT0,
    TX_STAT1
  } tx_state_e;

  typedef enum logic [1:0] {
    P_CMD,
    P_ARG0,
    P_ARG1,
    P_ARG2
  } prs_state_e;

  function automatic logic [INT_W-1:0] clamp_int(
    input logic [INT_W-1:0] v,
    input logic [INT_W-1:0] lo
  );
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/ccd_cmd_parser.sv
// Host command parser: one byte per accepted beat, owns int_next and the
// cont/single/status request flags. Ports: i_cmd_* byte in, i_frame_start /
// i_stat_take consume requests, o_* current scheduler settings.
module ccd_cmd_parser
  import ccd_pkg::*;
#(
  parameter int INT_MIN     = 10000,
  parameter int INT_DEFAULT = 100000
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic [7:0]       i_cmd_data,
  input  logic             i_cmd_take,
  input  logic             i_frame_start,
  input  logic             i_stat_take,
  output logic [INT_W-1:0] o_int_next,
  output logic             o_cont_mode,
  output logic             o_single_pend,
  output logic             o_stat_pend
);

  prs_state_e r_state;
  prs_state_e w_next;

  logic [7:0] r_arg0;
  logic [7:0] r_arg1;

  logic w_set_single;
  logic w_set_cont;
  logic w_stop;
  logic w_set_stat;
  logic w_ld_int;

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) r_state <= P_CMD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_cmd_take) begin
      case (r_state)
        P_CMD:   if (i_cmd_data == OP_SET_INT) w_next = P_ARG0;
        P_ARG0:  w_next = P_ARG1;
        P_ARG1:  w_next = P_ARG2;
        P_ARG2:  w_next = P_CMD;
        default: w_next = P_CMD;
      endcase
    end
  end

  always_comb begin
    w_set_single = 1'b0;
    w_set_cont   = 1'b0;
    w_stop       = 1'b0;
    w_set_stat   = 1'b0;
    w_ld_int     = i_cmd_take && (r_state == P_ARG2);
    if (i_cmd_take && (r_state == P_CMD)) begin
      unique case (1'b1)
        (i_cmd_data == OP_SINGLE): w_set_single = 1'b1;
        (i_cmd_data == OP_CONT):   w_set_cont   = 1'b1;
        (i_cmd_data == OP_STOP):   w_stop       = 1'b1;
        (i_cmd_data == OP_STATUS): w_set_stat   = 1'b1;
        default: ;
      endcase
    end
  end

  // A request arriving on the same cycle it is consumed wins over the clear,
  // so it is never lost.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_arg0        <= '0;
      r_arg1        <= '0;
      o_int_next    <= INT_W'(INT_DEFAULT);
      o_cont_mode   <= 1'b0;
      o_single_pend <= 1'b0;
      o_stat_pend   <= 1'b0;
    end else begin
      if (i_cmd_take && (r_state == P_ARG0)) r_arg0 <= i_cmd_data;
      if (i_cmd_take && (r_state == P_ARG1)) r_arg1 <= i_cmd_data;
      if (w_ld_int)
        o_int_next <= clamp_int({i_cmd_data, r_arg1, r_arg0},
                                INT_W'(INT_MIN));
      if (w_set_cont)  o_cont_mode <= 1'b1;
      else if (w_stop) o_cont_mode <= 1'b0;
      if (w_set_single)                o_single_pend <= 1'b1;
      else if (w_stop || i_frame_start) o_single_pend <= 1'b0;
      if (w_set_stat)       o_stat_pend <= 1'b1;
      else if (i_stat_take) o_stat_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/ccd_acq_sched.sv
// Acquisition scheduler top: period counter, TX FSM, frame/byte counters.
// Ports: cmd_* host bytes, frame_start/int_time to CCD timing, pix_* in, tx_* out, busy.
module ccd_acq_sched
  import ccd_pkg::*;
#(
  parameter int PIX_BYTES   = 7388,
  parameter int INT_MIN     = 10000,
  parameter int INT_DEFAULT = 100000
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             frame_start,
  output logic [INT_W-1:0] int_time,
  input  logic [7:0]       pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy
);

  localparam logic [15:0] LAST_BYTE = 16'(PIX_BYTES - 1);

  tx_state_e r_state;
  tx_state_e w_next;

  logic [INT_W-1:0] r_period;
  logic [INT_W-1:0] r_int_time;
  logic [INT_W-1:0] w_int_next;
  logic [7:0]       r_fcnt;
  logic [15:0]      r_bytes;
  logic             r_txv;
  logic [7:0]       r_txd;
  logic             r_busy;
  logic             r_cmd_rdy;

  logic       w_cont;
  logic       w_single;
  logic       w_stat_pend;
  logic       w_expired;
  logic       w_go;
  logic       w_fs;
  logic       w_stat_take;
  logic       w_xfer;
  logic       w_nxt_txv;
  logic [7:0] w_nxt_txd;

  ccd_cmd_parser #(
    .INT_MIN     (INT_MIN),
    .INT_DEFAULT (INT_DEFAULT)
  ) u_parser (
    .CLK_IN        (CLK_IN),
    .RST_N         (RST_N),
    .i_cmd_data    (cmd_data),
    .i_cmd_take    (cmd_valid && r_cmd_rdy),
    .i_frame_start (w_fs),
    .i_stat_take   (w_stat_take),
    .o_int_next    (w_int_next),
    .o_cont_mode   (w_cont),
    .o_single_pend (w_single),
    .o_stat_pend   (w_stat_pend)
  );

  assign w_expired = (r_period == '0);
  assign w_go      = (w_single || w_cont) && w_expired;
  assign w_xfer    = tx_valid && tx_ready;

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) r_state <= TX_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TX_IDLE: begin
        if (w_stat_pend) w_next = TX_STAT0;
        else if (w_go)   w_next = TX_HDR0;
      end
      TX_HDR0:   if (w_xfer) w_next = TX_HDR1;
      TX_HDR1:   if (w_xfer) w_next = TX_HDR2;
      TX_HDR2:   if (w_xfer) w_next = TX_PIXELS;
      TX_PIXELS: if (w_xfer && (r_bytes == LAST_BYTE)) w_next = TX_IDLE;
      TX_STAT0:  if (w_xfer) w_next = TX_STAT1;
      TX_STAT1:  if (w_xfer) w_next = TX_IDLE;
      default:   w_next = TX_IDLE;
    endcase
  end

  // Header/status bytes are registered on state entry; the status byte
  // therefore captures flags as they stand when STAT1 is entered.
  always_comb begin
    w_fs        = (r_state == TX_IDLE) && !w_stat_pend && w_go;
    w_stat_take = (r_state == TX_IDLE) && w_stat_pend;
    w_nxt_txv   = 1'b1;
    w_nxt_txd   = 8'h00;
    case (w_next)
      TX_HDR0:  w_nxt_txd = SYNC_H0;
      TX_HDR1:  w_nxt_txd = SYNC_H1;
      TX_HDR2:  w_nxt_txd = r_fcnt;
      TX_STAT0: w_nxt_txd = SYNC_ST;
      TX_STAT1: w_nxt_txd = {w_cont, w_single, w_expired, r_fcnt[4:0]};
      default:  w_nxt_txv = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_period   <= '0;
      r_int_time <= INT_W'(INT_DEFAULT);
      r_fcnt     <= '0;
      r_bytes    <= '0;
      r_txv      <= 1'b0;
      r_txd      <= '0;
      r_busy     <= 1'b0;
      r_cmd_rdy  <= 1'b0;
    end else begin
      r_cmd_rdy <= 1'b1;
      r_busy    <= (w_next != TX_IDLE);
      if (w_fs) begin
        r_period   <= w_int_next - 24'd1;
        r_int_time <= w_int_next;
      end else if (r_period != '0) begin
        r_period <= r_period - 24'd1;
      end
      if ((r_state == TX_HDR2) && w_xfer) r_fcnt <= r_fcnt + 8'd1;
      if (r_state != TX_PIXELS) r_bytes <= '0;
      else if (w_xfer)          r_bytes <= r_bytes + 16'd1;
      if (w_next != r_state) begin
        r_txv <= w_nxt_txv;
        r_txd <= w_nxt_txd;
      end
    end
  end

  assign cmd_ready   = r_cmd_rdy;
  assign frame_start = w_fs;
  assign int_time    = r_int_time;
  assign busy        = r_busy;
  assign pix_ready   = (r_state == TX_PIXELS) && tx_ready;
  assign tx_valid    = (r_state == TX_PIXELS) ? pix_valid : r_txv;
  assign tx_data     = (r_state == TX_PIXELS) ? pix_data  : r_txd;

endmodule

// File: tb/tb_ccd_acq_sched.sv
// Self-checking bench for ccd_acq_sched: byte-stream scoreboard, frame timing,
// status replies, random TX back-pressure and mid-frame reset.
module tb_ccd_acq_sched;

  localparam int PIX = 7388;

  logic        CLK_IN = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        frame_start;
  logic [23:0] int_time;
  logic [7:0]  pix_data = 8'h00;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;

  ccd_acq_sched dut (
    .CLK_IN      (CLK_IN),
    .RST_N       (RST_N),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .frame_start (frame_start),
    .int_time    (int_time),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy)
  );

  always #5 CLK_IN = ~CLK_IN;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK_IN) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + (i >> 8) * 3 + 1);
  endfunction

  function automatic logic [7:0] stat_b(input bit c, input bit s,
                                        input bit e, input int nf);
    return {c, s, e, 5'(nf)};
  endfunction

  // Pixel source and TX sink, driven 1 time unit after each rising edge.
  bit rnd_mode = 1'b0;
  bit pix_take = 1'b0;
  int pix_idx = 0;
  always @(posedge CLK_IN) begin
    #1;
    if (!RST_N) pix_idx = 0;
    else if (pix_take) pix_idx++;
    pix_data = pat(pix_idx);
    if (!pix_valid || pix_take)
      pix_valid = rnd_mode ? ($urandom_range(0, 7) != 0) : 1'b1;
    tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor on the falling edge: records transfers and frame starts and
  // counts protocol violations derived from the frame layout.
  logic [7:0] got[$];
  int fs_q[$];
  int last_pix_cyc = 0;
  int hdr_left = 0;
  int pix_left = 0;
  int viol = 0;
  bit hold_pend = 1'b0;
  logic [7:0] hold_d = 8'h00;
  always @(negedge CLK_IN) begin
    bit in_pix;
    pix_take = pix_valid && pix_ready;
    if (!RST_N) begin
      hdr_left = 0;
      pix_left = 0;
      hold_pend = 1'b0;
    end else begin
      if (frame_start) begin
        if (hdr_left != 0 || pix_left != 0 || busy) viol++;
        fs_q.push_back(cyc);
        hdr_left = 3;
      end
      in_pix = (hdr_left == 0) && (pix_left > 0);
      if (pix_ready && !in_pix) viol++;
      if (in_pix && (pix_ready !== tx_ready)) viol++;
      if (hold_pend && (!tx_valid || tx_data !== hold_d)) viol++;
      hold_pend = tx_valid && !tx_ready && !in_pix;
      hold_d = tx_data;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        if (hdr_left > 0) begin
          hdr_left--;
          if (hdr_left == 0) pix_left = PIX;
        end else if (pix_left > 0) begin
          pix_left--;
          if (pix_left == 0) last_pix_cyc = cyc;
        end
      end
    end
  end

  int pix_exp = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK_IN);
      #2;
    end
  endtask

  task automatic send(input logic [7:0] b);
    cmd_data = b;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic set_int(input logic [23:0] v);
    send(8'h01);
    send(v[7:0]);
    send(v[15:8]);
    send(v[23:16]);
  endtask

  task automatic get_byte(output logic [7:0] b, output bit ok);
    int t = 0;
    while (got.size() == 0 && t < 2000) begin
      tick(1);
      t++;
    end
    ok = (got.size() > 0);
    b = ok ? got.pop_front() : 8'h00;
  endtask

  task automatic exp_byte(input string tag, input logic [7:0] e);
    logic [7:0] b;
    bit ok;
    get_byte(b, ok);
    chk(tag, ok ? {24'h0, b} : 32'hFFFF_FFFF, {24'h0, e});
  endtask

  task automatic exp_pix(input int n);
    int bad = 0;
    logic [7:0] b;
    bit ok;
    for (int i = 0; i < n; i++) begin
      get_byte(b, ok);
      if (!ok) begin
        bad += n - i;
        break;
      end
      if (b !== pat(pix_exp)) bad++;
      pix_exp++;
    end
    chk("pixel_stream", bad, 0);
  endtask

  task automatic exp_hdr(input int fc);
    exp_byte("hdr0", 8'hA5);
    exp_byte("hdr1", 8'h5A);
    exp_byte("hdr_fcnt", 8'(fc));
  endtask

  task automatic wait_fs(input int lim, output int c);
    int t = 0;
    while (fs_q.size() == 0 && t < lim) begin
      tick(1);
      t++;
    end
    chk("frame_start_seen", (fs_q.size() > 0), 1);
    c = (fs_q.size() > 0) ? fs_q.pop_front() : -1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick(3);
    RST_N = 1'b1;
    got.delete();
    fs_q.delete();
    pix_exp = 0;
    tick(2);
  endtask

  initial begin
    int c0;
    int c1;
    int c2;
    int exp_c1;

    // Reset values
    tick(3);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_int_time", int_time, 100000);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    RST_N = 1'b1;
    tick(4);
    chk("cmd_ready_up", cmd_ready, 1);
    chk("idle_no_fs", fs_q.size(), 0);

    // Single frame with default exposure, then a status reply
    send(8'h02);
    wait_fs(20, c0);
    chk("single_int_time", int_time, 100000);
    exp_hdr(0);
    exp_pix(PIX);
    tick(5);
    send(8'h05);
    exp_byte("stat_sync", 8'h55);
    exp_byte("stat_single", stat_b(0, 0, 0, 1));
    tick(20);
    chk("single_only_once", fs_q.size(), 0);
    chk("viol_single", viol, 0);

    // Clamped exposure in continuous mode; STATUS and STOP mid-frame
    do_reset();
    set_int(24'd1000);
    send(8'h03);
    wait_fs(20, c0);
    chk("clamped_int_time", int_time, 10000);
    exp_hdr(0);
    exp_pix(PIX);
    wait_fs(12000, c1);
    chk("period_1", c1 - c0, 10000);
    exp_hdr(1);
    exp_pix(PIX);
    wait_fs(12000, c2);
    chk("period_2", c2 - c1, 10000);
    exp_hdr(2);
    exp_pix(2000);
    send(8'h05);
    send(8'h04);
    exp_pix(PIX - 2000);
    exp_byte("stat_sync_mid", 8'h55);
    exp_byte("stat_after_stop", stat_b(0, 0, 0, 3));
    while (cyc < c2 + 13000) tick(1);
    chk("no_fs_after_stop", fs_q.size(), 0);
    chk("busy_after_stop", busy, 0);
    chk("viol_cont", viol, 0);

    // Random back-pressure: frames back to back, then reset in PIXELS
    do_reset();
    set_int(24'd10000);
    rnd_mode = 1'b1;
    send(8'h03);
    wait_fs(40, c0);
    exp_hdr(0);
    exp_pix(PIX);
    wait_fs(20000, c1);
    exp_c1 = (last_pix_cyc + 1 > c0 + 10000) ? last_pix_cyc + 1 : c0 + 10000;
    chk("fs_after_idle", c1, exp_c1);
    exp_hdr(1);
    exp_pix(300);
    chk("viol_random", viol, 0);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_pix_ready", pix_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_int_time", int_time, 100000);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    rnd_mode = 1'b0;
    tick(3);
    RST_N = 1'b1;
    got.delete();
    fs_q.delete();
    pix_exp = 0;
    tick(2);
    send(8'h02);
    wait_fs(20, c0);
    exp_hdr(0);
    exp_pix(16);
    chk("viol_after_rst", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
